// File: rtl/priority_encoder_pipe.sv
// rtl/priority_encoder_pipe.sv - one-deep pipelined priority encoder with valid/ready handshake
// Define PRIORITY_ENCODER_PIPE_RR_MODE_EN for round-robin arbitration; fixed lowest-index otherwise.
module priority_encoder_pipe #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] code,
    output logic         none,
    output logic         out_valid,
    input  logic         out_ready
);

    generate
        if (W != $clog2(N) || N < 2 || N > 64) begin : g_bad_params
            $error("priority_encoder_pipe: need 2 <= N <= 64 and W == clog2(N)");
        end
    endgenerate

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [W-1:0] r_code;
    logic         r_none;
    logic [W-1:0] w_win;
    logic         w_found;
    logic         w_in_xfer;
    logic         w_out_xfer;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

`ifdef PRIORITY_ENCODER_PIPE_RR_MODE_EN
    logic [W-1:0] r_ptr;
    logic [W:0]   w_sum;
    logic [W-1:0] w_idx;

    // Walk offsets high to low so the smallest offset from r_ptr is the last match kept.
    always_comb begin
        w_found = 1'b0;
        w_win   = W'(N - 1);
        w_sum   = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (W + 1)'(k);
            if (w_sum >= (W + 1)'(N)) begin
                w_sum = w_sum - (W + 1)'(N);
            end
            w_idx = w_sum[W-1:0];
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_in_xfer && w_found) begin
            r_ptr <= (w_win == W'(N - 1)) ? '0 : w_win + 1'b1;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_win   = W'(N - 1);
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_found = 1'b1;
                w_win   = W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_in_xfer) w_next_state = S_FULL;
            S_FULL:  if (w_out_xfer && !w_in_xfer) w_next_state = S_EMPTY;
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_FULL);
        in_ready  = !out_valid || out_ready;
        code      = r_code;
        none      = r_none;
    end

    // Result registers load only on an accepted vector, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_none <= 1'b0;
        end else if (w_in_xfer) begin
            r_code <= w_win;
            r_none <= ~w_found;
        end
    end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// tb/tb_priority_encoder_pipe.sv - scoreboard bench for priority_encoder_pipe against a reference model
module tb_priority_encoder_pipe;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] code;
    logic         none;
    logic         out_valid;
    logic         out_ready = 1'b0;

    typedef struct {
        int c;
        bit n;
    } result_t;

    result_t exp_q[$];
    int      tests = 0;
    int      fails = 0;
    int      model_ptr = 0;

    priority_encoder_pipe #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .none      (none),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic result_t ref_enc(input logic [N-1:0] v, input int p);
        result_t r;
        r.c = N - 1;
        r.n = 1'b1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) begin
                r.c = idx;
                r.n = 1'b0;
                break;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic iv, input logic ordy);
        bit      accept;
        result_t r;
        @(negedge clk);
        req       = v;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        check("in_ready", int'(in_ready), int'(exp_q.size() == 0 || ordy));
        accept = iv && (exp_q.size() == 0 || ordy);
        @(posedge clk);
        #1;
        if (accept) begin
`ifdef PRIORITY_ENCODER_PIPE_RR_MODE_EN
            r = ref_enc(v, model_ptr);
            if (!r.n) model_ptr = (r.c + 1) % N;
`else
            r = ref_enc(v, 0);
`endif
            exp_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        req       = 8'h3C;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_code", int'(code), 0);
        check("rst_none", int'(none), 0);
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    // Monitor: compare whatever the DUT presents against the head of the expected queue.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("code", int'(code), exp_q[0].c);
                check("none", int'(none), int'(exp_q[0].n));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        do_reset();

        cycle(8'b1010_0100, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h80, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);

        // Backpressure: hold result while new requests are offered.
        cycle(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(8'h01, 1'b1, 1'b0);
        cycle(8'h01, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);

        // Simultaneous consume and accept.
        do_reset();
        cycle(8'h08, 1'b1, 1'b0);
        cycle(8'h40, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);

        // Idle with toggling req must not change state.
        for (int i = 0; i < 4; i++) cycle(N'($urandom), 1'b0, 1'($urandom_range(0, 1)));

        do_reset();
        for (int i = 0; i < 9; i++) cycle(8'hFF, 1'b1, 1'b1);
        do_reset();
        cycle(8'h81, 1'b1, 1'b1);
        cycle(8'h81, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);

        // Reset while FULL under backpressure.
        cycle(8'h20, 1'b1, 1'b0);
        cycle(8'h20, 1'b1, 1'b0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            v = N'($urandom);
            if ($urandom_range(0, 7) == 0) v = '0;
            cycle(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
